// File: rtl/cache_help.sv
// Shared types and address-field helpers for the L1 instruction cache.
// Address layout from LSB: 2 byte bits, word offset, set index, tag.
package cache_help;

   localparam int WORD_WIDTH    = 32;
   localparam int LINE_SIZE     = 128;
   localparam int BYTE_BITS     = 2;
   localparam int WORD_OFF_BITS = $clog2(LINE_SIZE / WORD_WIDTH);
   localparam int LINE_LSB      = BYTE_BITS + WORD_OFF_BITS;
   localparam int LINE_WORDS    = LINE_SIZE / WORD_WIDTH;

   typedef logic [WORD_WIDTH-1:0] Word;
   typedef logic [LINE_SIZE-1:0]  Line;

   typedef enum logic [2:0] {
      READY,
      LOOKUP,
      MISS_REQ,
      FILL,
      RESPOND
   } L1IcacheState;

   // Word position inside the line
   function automatic logic [31:0] addr_word_offset(input Word addr);
      return (addr >> BYTE_BITS) & ((32'd1 << WORD_OFF_BITS) - 32'd1);
   endfunction

   // Set index for a cache with num_sets sets
   function automatic logic [31:0] addr_index(input Word addr, input int unsigned num_sets);
      return (addr >> LINE_LSB) & (num_sets - 32'd1);
   endfunction

   // Tag: everything above the index field
   function automatic logic [31:0] addr_tag(input Word addr, input int unsigned num_sets);
      return addr >> (LINE_LSB + $clog2(num_sets));
   endfunction

   // Address with the in-line offset bits cleared
   function automatic Word line_base(input Word addr);
      return addr & ~((32'd1 << LINE_LSB) - 32'd1);
   endfunction

endpackage

// File: rtl/l1_icache_way.sv
// One cache way: tag RAM and line RAM sharing a single index and enable.
module l1_icache_way #(
   parameter int NUM_SETS   = 64,
   parameter int TAG_WIDTH  = 22,
   parameter int LINE_WIDTH = 128
) (
   input  logic                        clk_in,
   input  logic                        enable_in,
   input  logic                        write_in,
   input  logic [$clog2(NUM_SETS)-1:0] index_in,
   input  logic [TAG_WIDTH-1:0]        tag_in,
   input  logic [LINE_WIDTH-1:0]       line_in,
   output logic [TAG_WIDTH-1:0]        tag_out,
   output logic [LINE_WIDTH-1:0]       line_out
);

   xilinx_single_port_ram_read_first #(
      .RAM_WIDTH(TAG_WIDTH),
      .RAM_DEPTH(NUM_SETS)
   ) tag_ram (
      .clk_in   (clk_in),
      .enable_in(enable_in),
      .write_in (write_in),
      .addr_in  (index_in),
      .data_in  (tag_in),
      .data_out (tag_out)
   );

   xilinx_single_port_ram_read_first #(
      .RAM_WIDTH(LINE_WIDTH),
      .RAM_DEPTH(NUM_SETS)
   ) line_ram (
      .clk_in   (clk_in),
      .enable_in(enable_in),
      .write_in (write_in),
      .addr_in  (index_in),
      .data_in  (line_in),
      .data_out (line_out)
   );

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port block RAM, read-first: the read returns the old contents
// when the same address is written. Output holds while enable is low.
module xilinx_single_port_ram_read_first #(
   parameter int RAM_WIDTH = 32,
   parameter int RAM_DEPTH = 64
) (
   input  logic                         clk_in,
   input  logic                         enable_in,
   input  logic                         write_in,
   input  logic [$clog2(RAM_DEPTH)-1:0] addr_in,
   input  logic [RAM_WIDTH-1:0]         data_in,
   output logic [RAM_WIDTH-1:0]         data_out
);

   logic [RAM_WIDTH-1:0] mem_reg [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] data_reg;

   // Registered read of the old word, optional write of the new one
   always_ff @(posedge clk_in) begin
      if (enable_in) begin
         if (write_in) begin
            mem_reg[addr_in] <= data_in;
         end
         data_reg <= mem_reg[addr_in];
      end
   end

   assign data_out = data_reg;

endmodule

// File: rtl/l1_icache_assoc.sv
// Set-associative L1 instruction cache, blocking, one miss at a time.
// Valid bits and round-robin pointers live in flops; tags and lines in BRAM.
// Optional: define L1_ICACHE_PERF_COUNTERS_EN to add hit/miss counters.
module l1_icache_assoc
   import cache_help::*;
#(
   parameter int NUM_WAYS = 2,
   parameter int NUM_SETS = 64
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   output logic                 fetch_request_ready_out,
   input  logic                 fetch_request_valid_in,
   input  logic [31:0]          fetch_request_address_in,
   input  logic                 fetch_response_ready_in,
   output logic                 fetch_response_valid_out,
   output logic [31:0]          fetch_response_data_out,
   input  logic                 l2_cache_request_ready_in,
   output logic                 l2_cache_request_valid_out,
   output logic [31:0]          l2_cache_request_address_out,
   output logic                 l2_cache_response_ready_out,
   input  logic                 l2_cache_response_valid_in,
   input  logic [LINE_SIZE-1:0] l2_cache_response_data_in,
   input  logic                 invalidate_all_in
`ifdef L1_ICACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0]          hit_count_out,
   output logic [31:0]          miss_count_out
`endif
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int TAG_W = WORD_WIDTH - LINE_LSB - IDX_W;

   L1IcacheState state_reg;

   logic [31:0]        req_addr_reg;
   logic [31:0]        resp_word_reg;
   logic [WAY_W-1:0]   victim_reg;
   logic               victim_was_free_reg;
   logic               ready_reg;
   logic               resp_valid_reg;
   logic               l2_req_valid_reg;
   logic               l2_resp_ready_reg;

   logic [NUM_WAYS-1:0] valid_reg [NUM_SETS];
   logic [WAY_W-1:0]    rr_reg    [NUM_SETS];

   logic [IDX_W-1:0]         req_index;
   logic [IDX_W-1:0]         accept_index;
   logic [IDX_W-1:0]         ram_index;
   logic [TAG_W-1:0]         req_tag;
   logic [WORD_OFF_BITS-1:0] req_word;

   logic [TAG_W-1:0]     tag_rd  [NUM_WAYS];
   logic [LINE_SIZE-1:0] line_rd [NUM_WAYS];
   logic [NUM_WAYS-1:0]  way_enable;
   logic [NUM_WAYS-1:0]  way_write;

   logic [NUM_WAYS-1:0]  set_valid;
   logic [NUM_WAYS-1:0]  match_vec;
   logic                 hit;
   logic                 has_free;
   logic [WAY_W-1:0]     hit_way;
   logic [WAY_W-1:0]     free_way;
   logic [WAY_W-1:0]     rr_next;
   logic                 lookup;
   logic                 accept;
   logic                 fill_fire;

   logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] hit_words;
   logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] fill_words;

   assign req_index    = IDX_W'(addr_index(req_addr_reg, NUM_SETS));
   assign req_tag      = TAG_W'(addr_tag(req_addr_reg, NUM_SETS));
   assign req_word     = WORD_OFF_BITS'(addr_word_offset(req_addr_reg));
   assign accept_index = IDX_W'(addr_index(fetch_request_address_in, NUM_SETS));

   assign lookup    = (state_reg == LOOKUP);
   assign accept    = ready_reg && fetch_request_valid_in && !rst_in;
   assign fill_fire = l2_resp_ready_reg && l2_cache_response_valid_in && !rst_in;
   assign ram_index = (state_reg == READY) ? accept_index : req_index;
   assign set_valid = valid_reg[req_index];

   generate
      for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
         assign way_write[gi]  = fill_fire && (victim_reg == WAY_W'(gi));
         assign way_enable[gi] = accept || way_write[gi];
         assign match_vec[gi]  = set_valid[gi] && (tag_rd[gi] == req_tag);

         l1_icache_way #(
            .NUM_SETS  (NUM_SETS),
            .TAG_WIDTH (TAG_W),
            .LINE_WIDTH(LINE_SIZE)
         ) way_inst (
            .clk_in   (clk_in),
            .enable_in(way_enable[gi]),
            .write_in (way_write[gi]),
            .index_in (ram_index),
            .tag_in   (req_tag),
            .line_in  (l2_cache_response_data_in),
            .tag_out  (tag_rd[gi]),
            .line_out (line_rd[gi])
         );
      end
   endgenerate

   // Lowest-index matching way and lowest-index invalid way of the set
   always_comb begin
      hit_way  = '0;
      free_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (match_vec[w]) begin
            hit_way = WAY_W'(w);
         end
         if (!set_valid[w]) begin
            free_way = WAY_W'(w);
         end
      end
   end

   assign hit      = |match_vec;
   assign has_free = ~&set_valid;
   assign rr_next  = (rr_reg[req_index] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_reg[req_index] + 1'b1;

   assign hit_words  = line_rd[hit_way];
   assign fill_words = l2_cache_response_data_in;

   assign fetch_request_ready_out      = ready_reg;
   assign fetch_response_valid_out     = resp_valid_reg || (lookup && hit);
   assign fetch_response_data_out      = resp_valid_reg ? resp_word_reg : hit_words[req_word];
   assign l2_cache_request_valid_out   = l2_req_valid_reg;
   assign l2_cache_request_address_out = line_base(req_addr_reg);
   assign l2_cache_response_ready_out  = l2_resp_ready_reg;

   // Control FSM with registered handshake outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg           <= READY;
         ready_reg           <= 1'b1;
         resp_valid_reg      <= 1'b0;
         l2_req_valid_reg    <= 1'b0;
         l2_resp_ready_reg   <= 1'b0;
         req_addr_reg        <= '0;
         resp_word_reg       <= '0;
         victim_reg          <= '0;
         victim_was_free_reg <= 1'b0;
      end else begin
         case (state_reg)
            READY: begin
               if (accept) begin
                  req_addr_reg <= fetch_request_address_in;
                  ready_reg    <= 1'b0;
                  state_reg    <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  if (fetch_response_ready_in) begin
                     ready_reg <= 1'b1;
                     state_reg <= READY;
                  end
               end else begin
                  victim_reg          <= has_free ? free_way : rr_reg[req_index];
                  victim_was_free_reg <= has_free;
                  l2_req_valid_reg    <= 1'b1;
                  state_reg           <= MISS_REQ;
               end
            end
            MISS_REQ: begin
               if (l2_cache_request_ready_in) begin
                  l2_req_valid_reg  <= 1'b0;
                  l2_resp_ready_reg <= 1'b1;
                  state_reg         <= FILL;
               end
            end
            FILL: begin
               if (fill_fire) begin
                  l2_resp_ready_reg <= 1'b0;
                  resp_word_reg     <= fill_words[req_word];
                  resp_valid_reg    <= 1'b1;
                  state_reg         <= RESPOND;
               end
            end
            RESPOND: begin
               if (fetch_response_ready_in) begin
                  resp_valid_reg <= 1'b0;
                  ready_reg      <= 1'b1;
                  state_reg      <= READY;
               end
            end
            default: begin
               state_reg <= READY;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   // Valid bits: invalidate-all wins over a fill in the same cycle
   always_ff @(posedge clk_in) begin
      if (rst_in || invalidate_all_in) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_reg[s] <= '0;
         end
      end else if (fill_fire) begin
         valid_reg[req_index][victim_reg] <= 1'b1;
      end
   end

   // Round-robin pointer moves only when a valid line was evicted
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            rr_reg[s] <= '0;
         end
      end else if (fill_fire && !victim_was_free_reg) begin
         rr_reg[req_index] <= rr_next;
      end
   end

   // Flag duplicate tags in a set; the lowest matching way is returned
   always_ff @(posedge clk_in) begin
      if (!rst_in && lookup) begin
         assert ($countones(match_vec) <= 1);
      end
   end

`ifdef L1_ICACHE_PERF_COUNTERS_EN
   logic [31:0] hit_count_reg;
   logic [31:0] miss_count_reg;

   // One hit per completed hit response, one miss per LOOKUP miss decision
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else if (lookup) begin
         if (hit && fetch_response_ready_in) begin
            hit_count_reg <= hit_count_reg + 32'd1;
         end
         if (!hit) begin
            miss_count_reg <= miss_count_reg + 32'd1;
         end
      end
   end

   assign hit_count_out  = hit_count_reg;
   assign miss_count_out = miss_count_reg;
`endif

endmodule
